// File: rtl/full_adder_checker_if.sv
// Bus between full_adder_checker and the adder under test / run controller.
// master: the checker side; slave: the adder plus whoever requests runs.
interface full_adder_checker_if;
  logic       Start;
  logic       A;
  logic       B;
  logic       Cin;
  logic       Sum;
  logic       Cout;
  logic       Busy;
  logic       Done;
  logic       Pass;
  logic [3:0] ErrCount;
  logic [2:0] FirstFailVec;
  logic       FailSeen;

  modport master (
    input  Start, Sum, Cout,
    output A, B, Cin, Busy, Done, Pass, ErrCount, FirstFailVec, FailSeen
  );

  modport slave (
    output Start, Sum, Cout,
    input  A, B, Cin, Busy, Done, Pass, ErrCount, FirstFailVec, FailSeen
  );
endinterface

// File: rtl/full_adder_checker.sv
// Sweeps all 8 {Cin,A,B} vectors through an external full adder and scores it.
// Optional macro FA_CHECK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module full_adder_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  full_adder_checker_if.master        bus,
  output logic [2:0]                  dbg_state
);

  // Handshake: Start is a one-cycle request honoured only while Busy=0
  // (IDLE or DONE); Busy is high for the whole sweep, then Done holds the
  // results until the next accepted Start or Rst.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  state_t     state, state_nx;
  logic [2:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [3:0] err_cnt;
  logic [2:0] first_fail;
  logic       fail_seen;
  logic       exp_sum, exp_cout, mismatch, start_run, stop_now;

  // vec is also the driven stimulus, so the reference is computed from it
  assign exp_sum   = ^vec;
  assign exp_cout  = (vec[1] & vec[0]) | (vec[1] & vec[2]) | (vec[0] & vec[2]);
  assign mismatch  = (state == SAMPLE) && ((bus.Sum != exp_sum) || (bus.Cout != exp_cout));
  assign start_run = ((state == IDLE) || (state == DONE)) && bus.Start;

`ifdef FA_CHECK_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.Start) state_nx = DRIVE;
      DRIVE:  state_nx = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
      SAMPLE: begin
        if (stop_now)                                   state_nx = DONE;
        else if ((vec != 3'd7) || (pass_cnt != PASS_LAST)) state_nx = DRIVE;
        else                                            state_nx = DONE;
      end
      DONE:   if (bus.Start) state_nx = DRIVE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || start_run) begin
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        DRIVE:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != 4'd15) err_cnt <= err_cnt + 4'd1;
            if (!fail_seen) begin
              first_fail <= vec;
              fail_seen  <= 1'b1;
            end
          end
          // vec wraps 7->0 naturally at the start of the next pass
          if (state_nx == DRIVE) begin
            vec <= vec + 3'd1;
            if (vec == 3'd7) pass_cnt <= pass_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A            = vec[1];
  assign bus.B            = vec[0];
  assign bus.Cin          = vec[2];
  assign bus.Busy         = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign bus.Done         = (state == DONE);
  assign bus.Pass         = (state == DONE) && (err_cnt == 4'd0);
  assign bus.ErrCount     = err_cnt;
  assign bus.FirstFailVec = first_fail;
  assign bus.FailSeen     = fail_seen;
  assign dbg_state        = state;

endmodule
